// File: rtl/fpu_result_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fpu_result_sequencer
// Description : Registered, in-order result sequencer for the FPU top. Issued
//               opcodes are queued in a tag FIFO; each unit result is taken
//               only when its channel matches the FIFO head and is returned
//               through a valid/ready output register.
//               Optional feature macro: SEQ_ILLEGAL_NAN_EN (illegal opcodes
//               retire as an ordered quiet-NaN result instead of silently).
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_result_sequencer #(
    parameter int               WIDTH = 32,
    parameter int               NCH   = 4,
    parameter int               OPW   = 3,
    parameter int               DEPTH = 8,
    parameter logic [WIDTH-1:0] QNAN  = WIDTH'(32'h7FC00000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [OPW-1:0]       issue_op,
    output logic                 issue_ready,
    input  logic [NCH-1:0]       res_valid,
    input  logic [NCH*WIDTH-1:0] res_data,
    output logic [NCH-1:0]       res_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [OPW-1:0]       out_op,
    output logic                 err_illegal
);

    localparam int             AW          = $clog2(DEPTH);
    localparam logic [AW:0]    c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [OPW:0]   c_NCH_EXT   = (OPW+1)'(NCH);
`ifdef SEQ_ILLEGAL_NAN_EN
    localparam logic           c_NAN_EN    = 1'b1;
`else
    localparam logic           c_NAN_EN    = 1'b0;
`endif

    // Tag FIFO state
    logic [OPW-1:0] mem_q [DEPTH];
    logic [OPW-1:0] mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;

    // Output register state
    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] out_data_q,    out_data_d;
    logic [OPW-1:0]   out_op_q,      out_op_d;
    logic             err_illegal_q, err_illegal_d;

    logic             empty;
    logic             can_load;
    logic [OPW-1:0]   head_op;
    logic             head_legal;
    logic [NCH-1:0]   hit;
    logic             transfer;
    logic             illegal_fire;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sel_data;

    assign empty        = (count_q == '0);
    assign issue_ready  = (count_q != c_DEPTH_CNT);
    assign can_load     = !out_valid_q || out_ready;
    assign head_op      = mem_q[rd_ptr_q];
    assign head_legal   = ({1'b0, head_op} < c_NCH_EXT);
    assign push         = issue_valid && issue_ready;
    assign transfer     = |hit;
    assign illegal_fire = !empty && !head_legal && can_load;
    assign pop          = transfer || illegal_fire;

    // Only the channel named by a legal head may be accepted, and only when
    // the output register can take the result.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign res_ready[c] = head_legal && !empty && can_load && (head_op == OPW'(c));
        assign hit[c]       = res_valid[c] && res_ready[c];
    end

    // Select the head channel's result data
    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (head_op == OPW'(c)) begin
                sel_data = res_data[c*WIDTH +: WIDTH];
            end
        end
    end

    // Tag FIFO next state: write on push, advance head on pop, track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = issue_op;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Output register next state: load on transfer (or NaN retire), hold
    // under back-pressure, otherwise drop valid once consumed.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_op_d      = out_op_q;
        err_illegal_d = illegal_fire;
        if (can_load) begin
            if (transfer) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_op_d    = head_op;
            end else if (illegal_fire && c_NAN_EN) begin
                out_valid_d = 1'b1;
                out_data_d  = QNAN;
                out_op_d    = head_op;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_op_q      <= '0;
            err_illegal_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_op_q      <= out_op_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_op      = out_op_q;
    assign err_illegal = err_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_result_sequencer
// Description : Directed scoreboard bench for fpu_result_sequencer. Expected
//               results are queued at issue time and popped by a monitor on
//               every output handshake. Per-channel unit models hold results
//               until accepted. Honours SEQ_ILLEGAL_NAN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_result_sequencer;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int OPW   = 3;
    localparam int DEPTH = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic [OPW-1:0]       issue_op;
    logic                 issue_ready;
    logic [NCH-1:0]       res_valid;
    logic [NCH*WIDTH-1:0] res_data;
    logic [NCH-1:0]       res_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [OPW-1:0]       out_op;
    logic                 err_illegal;

    always #5 clk = ~clk;

    fpu_result_sequencer #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .OPW   (OPW),
        .DEPTH (DEPTH),
        .QNAN  (32'h7FC00000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_op    (issue_op),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_op      (out_op),
        .err_illegal (err_illegal)
    );

    typedef struct packed {
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;

    // Per-channel unit model: ring of pending results, head presented until taken
    logic [WIDTH-1:0] ubuf  [NCH][16];
    int               uhead [NCH];
    int               utail [NCH];
    logic [NCH-1:0]   acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic give(input int ch, input logic [WIDTH-1:0] d);
        ubuf[ch][utail[ch] % 16] = d;
        utail[ch]++;
    endtask

    // Issue one opcode (caller guarantees issue_ready) and record its expected result
    task automatic issue(input logic [OPW-1:0] op, input logic [WIDTH-1:0] d);
        issue_valid = 1'b1;
        issue_op    = op;
        if (int'(op) < NCH) begin
            sb.push_back({op, d});
        end else begin
`ifdef SEQ_ILLEGAL_NAN_EN
            sb.push_back({op, 32'h7FC00000});
`endif
        end
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
        end
        tick();
    endtask

    // Unit models: accept on handshake seen before the edge, then re-present
    initial begin
        res_valid = '0;
        res_data  = '0;
        for (int c = 0; c < NCH; c++) begin
            uhead[c] = 0;
            utail[c] = 0;
        end
        forever begin
            @(negedge clk);
            acc = res_valid & res_ready;
            @(posedge clk);
            #2;
            if (!rst_n) begin
                for (int c = 0; c < NCH; c++) uhead[c] = utail[c];
                res_valid = '1;
                res_data  = {NCH{32'hDEADBEEF}};
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    if (acc[c]) uhead[c]++;
                    res_valid[c]                = (uhead[c] != utail[c]);
                    res_data[c*WIDTH +: WIDTH]  = ubuf[c][uhead[c] % 16];
                end
            end
        end
    end

    // Monitor: compare every output handshake against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (err_illegal) err_pulses++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h/op%0d expected none", out_data, out_op);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_op", 64'(out_op), 64'(e.op));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        issue_op    = '0;
        out_ready   = 1'b0;

        // Reset with issue activity applied; unit model drives junk results
        tick();
        issue_valid = 1'b1;
        issue_op    = 3'd2;
        tick();
        tick();
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_res_ready", 64'(res_ready), 64'd0);
        chk("rst_err_illegal", 64'(err_illegal), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_op", 64'(out_op), 64'd0);

        // Order: head op2 must block ch0 even though ch0 is valid first
        out_ready = 1'b1;
        issue(3'd2, 32'h40000000);
        issue(3'd0, 32'h3F800000);
        give(0, 32'h3F800000);
        tick();
        give(2, 32'h40000000);
        chk("order_res_ready", 64'(res_ready), 64'b0100);
        drain();

        // Back-pressure: one result in the output register, three queued
        out_ready = 1'b0;
        issue(3'd0, 32'h3FC00000); give(0, 32'h3FC00000);
        issue(3'd1, 32'h40400000); give(1, 32'h40400000);
        issue(3'd2, 32'h40800000); give(2, 32'h40800000);
        issue(3'd3, 32'h40A00000); give(3, 32'h40A00000);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_data", 64'(out_data), 64'h3FC00000);
            chk("bp_res_ready", 64'(res_ready), 64'd0);
            chk("bp_count", 64'(dut.count_q), 64'd3);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_consecutive", 64'(out_valid), 64'd1);
            tick();
        end
        drain();
        chk("bp_idle", 64'(out_valid), 64'd0);

        // Full: 8 tags with no results, then a refused push
        for (int i = 0; i < 8; i++) issue(OPW'(i % 4), 32'h10000000 + 32'(i));
        chk("full_issue_ready", 64'(issue_ready), 64'd0);
        chk("full_count", 64'(dut.count_q), 64'd8);
        issue_valid = 1'b1;
        issue_op    = 3'd1;
        tick();
        issue_valid = 1'b0;
        chk("full_refused_count", 64'(dut.count_q), 64'd8);
        for (int i = 0; i < 8; i++) give(i % 4, 32'h10000000 + 32'(i));
        drain();
        chk("full_empty_count", 64'(dut.count_q), 64'd0);
        // Wrap: 8 more in a different channel order
        for (int i = 0; i < 8; i++) issue(OPW'(3 - (i % 4)), 32'h20000000 + 32'(i));
        for (int i = 0; i < 8; i++) give(3 - (i % 4), 32'h20000000 + 32'(i));
        drain();

        // Simultaneous push and pop at count 4
        issue(3'd1, 32'h30000001);
        issue(3'd2, 32'h30000002);
        issue(3'd3, 32'h30000003);
        issue(3'd0, 32'h30000004);
        chk("sim_count_before", 64'(dut.count_q), 64'd4);
        give(1, 32'h30000001);
        tick();
        issue_valid = 1'b1;
        issue_op    = 3'd2;
        sb.push_back({3'd2, 32'h30000005});
        tick();
        issue_valid = 1'b0;
        chk("sim_count_after", 64'(dut.count_q), 64'd4);
        give(2, 32'h30000002);
        give(3, 32'h30000003);
        give(0, 32'h30000004);
        give(2, 32'h30000005);
        drain();

        // Illegal opcodes 5 and 4 (first illegal value) around a legal result
        p = err_pulses;
        issue(3'd5, 32'h0);
        issue(3'd1, 32'h3F000000);
        issue(3'd4, 32'h0);
        issue(3'd3, 32'h3E800000);
        give(1, 32'h3F000000);
        give(3, 32'h3E800000);
        drain();
        tick();
        chk("illegal_err_pulses", 64'(err_pulses - p), 64'd2);
        chk("illegal_idle_err", 64'(err_illegal), 64'd0);
        chk("final_count", 64'(dut.count_q), 64'd0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
